// File: rtl/aes_output_buffer.sv
// aes_output_buffer
//   Return-path buffer for the AES core. The result block is captured when the
//   core pulses done_i. It then leaves as N_WORDS words on a valid/ready
//   handshake, least-significant word first: text_i[WORD_W-1:0] goes first and
//   the top word goes last.
//
// Ports
//   clk      clock; all state changes on the rising edge
//   rst      asynchronous reset, active-low
//   done_i   core result strobe; text_i is sampled in the same cycle
//   text_i   result block, WORD_W*N_WORDS bits
//   ready_i  downstream accepts text_o this cycle
//   text_o   current output word (0 while idle)
//   valid_o  text_o holds a valid word
//   last_o   text_o is the final word of the block
//   busy_o   a block is held or being sent
//   ovf_o    pulses for one cycle after a done_i was dropped because the
//            buffer was busy
module aes_output_buffer #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      done_i,
  input  logic [WORD_W*N_WORDS-1:0] text_i,
  input  logic                      ready_i,
  output logic [WORD_W-1:0]         text_o,
  output logic                      valid_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      ovf_o
);

  localparam int BLK_W = WORD_W * N_WORDS;
  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BLK_W-1:0] hold_q, hold_d;
  logic             ovf_q, ovf_d;

  logic xfer;
  logic xfer_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    ovf_d     = 1'b0;
    xfer      = (state_q == ST_SEND) && ready_i;
    xfer_last = xfer && (idx_q == LAST_IDX);

    case (state_q)
      ST_IDLE: begin
        if (done_i) begin
          hold_d  = text_i;
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer_last) begin
          // A new result arriving with the final word is taken at once, so
          // consecutive blocks stream without an idle bubble.
          idx_d = '0;
          if (done_i) begin
            hold_d = text_i;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
          end
          // The buffer cannot accept this block; flag the loss.
          ovf_d = done_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs depend only on flops, so ready_i never reaches valid_o
  // combinationally.
  always_comb begin
    text_o = '0;
    if (state_q == ST_SEND) begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          text_o = hold_q[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  assign valid_o = (state_q == ST_SEND);
  assign busy_o  = (state_q == ST_SEND);
  assign last_o  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_aes_output_buffer.sv
module tb_aes_output_buffer;

  logic         clk;
  logic         rst;
  logic         done_i;
  logic [127:0] text_i;
  logic         ready_i;
  logic [31:0]  text_o;
  logic         valid_o;
  logic         last_o;
  logic         busy_o;
  logic         ovf_o;

  int errors = 0;
  int checks = 0;

  // Reference model: the words still owed to downstream for the current block.
  logic [31:0]  exp_q[$];
  logic [127:0] sent[$];
  logic         m_ovf;
  int           n_acc;

  // Observed transfers, taken from the DUT just before each edge.
  logic [31:0]  got[$];
  logic         obs_xfer;
  logic         obs_last;
  logic [31:0]  obs_word;

  aes_output_buffer #(.WORD_W(32), .N_WORDS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .done_i  (done_i),
    .text_i  (text_i),
    .ready_i (ready_i),
    .text_o  (text_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_text();
    return (exp_q.size() != 0) ? exp_q[0] : 32'h0;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    sent.delete();
    m_ovf = 1'b0;
    n_acc = 0;
  endtask

  // Drive one cycle of inputs, record any transfer, update the model at the
  // edge. Returns 1 ns after the edge.
  task automatic step(input logic d, input logic [127:0] t, input logic r);
    int  sz;
    logic fin;
    done_i  = d;
    text_i  = t;
    ready_i = r;
    #1;
    obs_xfer = valid_o && ready_i;
    obs_last = last_o;
    obs_word = text_o;
    if (obs_xfer) got.push_back(obs_word);
    @(posedge clk);
    sz  = exp_q.size();
    fin = 1'b0;
    if (sz > 0 && r) begin
      void'(exp_q.pop_front());
      fin = (sz == 1);
    end
    m_ovf = 1'b0;
    if (d) begin
      if (sz == 0 || fin) begin
        for (int i = 0; i < 4; i++) exp_q.push_back(t[i*32 +: 32]);
        sent.push_back(t);
        n_acc++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [127:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [127:0] a;
    rst = 1'b1; done_i = 1'b0; ready_i = 1'b0; text_i = '0;
    #1 rst = 1'b0;
    #1;
    checks++; if (text_o !== 32'h0) begin errors++; $display("FAIL reset_text got=%h exp=0", text_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
    // Reset while word 2 of a block is on the output.
    a = rand_blk();
    step(1'b1, a, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    checks++; if (text_o !== a[95:64]) begin errors++; $display("FAIL midrst_word2 got=%h exp=%h", text_o, a[95:64]); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({valid_o, busy_o, last_o, ovf_o} !== 4'b0) begin errors++; $display("FAIL midrst_ctrl got=%b exp=0000", {valid_o, busy_o, last_o, ovf_o}); end
    checks++; if (text_o !== 32'h0) begin errors++; $display("FAIL midrst_text got=%h exp=0", text_o); end
    @(posedge clk);
    #1 rst = 1'b1;
    model_clear();
    step(1'b0, '0, 1'b1);
    checks++; if ({valid_o, busy_o, text_o} !== 34'h0) begin errors++; $display("FAIL midrst_idle got=%b/%b/%h exp=0/0/0", valid_o, busy_o, text_o); end
  endtask

  task automatic test_basic();
    logic [31:0] w;
    step(1'b1, 128'h33333333_22222222_11111111_00000000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w = 32'h11111111 * i;
      checks++; if (text_o !== w) begin errors++; $display("FAIL basic_word%0d got=%h exp=%h", i, text_o, w); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid%0d got=%b exp=1", i, valid_o); end
      checks++; if (last_o !== (i == 3)) begin errors++; $display("FAIL basic_last%0d got=%b exp=%b", i, last_o, (i == 3)); end
      step(1'b0, rand_blk(), 1'b1);
    end
    checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL basic_done got=busy%b valid%b exp=0/0", busy_o, valid_o); end
  endtask

  task automatic test_backpressure();
    got.delete();
    step(1'b1, 128'h33333333_22222222_11111111_00000000, 1'b1);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, rand_blk(), 1'b0);
      checks++; if (text_o !== 32'h11111111 || valid_o !== 1'b1) begin errors++; $display("FAIL bp_stall%0d got=%h/%b exp=11111111/1", i, text_o, valid_o); end
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== 32'h11111111 * i) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], 32'h11111111 * i); end
    end
  endtask

  task automatic test_overflow();
    logic [127:0] a, b;
    a = rand_blk(); b = rand_blk();
    got.delete();
    step(1'b1, a, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, b, 1'b0);
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", ovf_o); end
    checks++; if (text_o !== a[63:32]) begin errors++; $display("FAIL ovf_hold got=%h exp=%h", text_o, a[63:32]); end
    step(1'b0, '0, 1'b1);
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf_o); end
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    checks++; if (got.size() != 4 || busy_o !== 1'b0) begin errors++; $display("FAIL ovf_count got=%0d/%b exp=4/0", got.size(), busy_o); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== a[i*32 +: 32]) begin errors++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got[i], a[i*32 +: 32]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    a = rand_blk(); b = rand_blk();
    got.delete();
    step(1'b1, a, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, b, 1'b1);
    checks++; if (text_o !== b[31:0] || valid_o !== 1'b1) begin errors++; $display("FAIL b2b_first got=%h/%b exp=%h/1", text_o, valid_o, b[31:0]); end
    checks++; if (ovf_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL b2b_flags got=ovf%b busy%b exp=0/1", ovf_o, busy_o); end
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== ((i < 4) ? a[i*32 +: 32] : b[(i-4)*32 +: 32])) begin
        errors++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got[i], (i < 4) ? a[i*32 +: 32] : b[(i-4)*32 +: 32]);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] asm_blk, ref_blk;
    int wcnt, cyc, n_done, rerr;
    model_clear();
    asm_blk = '0; wcnt = 0; cyc = 0; n_done = 0; rerr = 0;
    while (n_done < 100 && cyc < 20000) begin
      step(($urandom_range(3) == 0), rand_blk(), $urandom_range(1));
      cyc++;
      if (obs_xfer) begin
        asm_blk[wcnt*32 +: 32] = obs_word;
        wcnt++;
        if (obs_last) begin
          checks++;
          ref_blk = (sent.size() != 0) ? sent.pop_front() : 128'hx;
          if (wcnt != 4 || asm_blk !== ref_blk) begin
            errors++; $display("FAIL rnd_block%0d got=%h (%0d words) exp=%h", n_done, asm_blk, wcnt, ref_blk);
          end
          wcnt = 0; n_done++;
        end else if (wcnt >= 4) begin
          checks++; errors++; $display("FAIL rnd_nolast got=%0d words exp=last on 4th", wcnt); wcnt = 0;
        end
      end
      checks++;
      if (text_o !== exp_text() || valid_o !== (exp_q.size() != 0) || busy_o !== (exp_q.size() != 0) ||
          last_o !== (exp_q.size() == 1) || ovf_o !== m_ovf) begin
        errors++; rerr++;
        if (rerr < 10)
          $display("FAIL rnd_cycle%0d got=%h v%b b%b l%b o%b exp=%h v%b b%b l%b o%b", cyc, text_o, valid_o, busy_o, last_o, ovf_o,
                   exp_text(), (exp_q.size() != 0), (exp_q.size() != 0), (exp_q.size() == 1), m_ovf);
      end
    end
    checks++; if (n_done < 100) begin errors++; $display("FAIL rnd_timeout got=%0d blocks exp=100", n_done); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
